// File: rtl/bcd_countdown_timer.sv
`timescale 1ns/1ps
// HH:MM:SS BCD countdown timer with 1 Hz prescaler, load/start/pause/clear
// control, sanitised loading, optional auto-reload and a stretched alarm.
module bcd_countdown_timer #(
    parameter int unsigned TICK_DIV     = 50000000,
    parameter int unsigned ALARM_CYCLES = 8,
    parameter int unsigned AUTO_RELOAD  = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic [3:0] setHour10,
    input  logic [3:0] setHour1,
    input  logic [3:0] setMinute10,
    input  logic [3:0] setMinute1,
    input  logic [3:0] setSecond10,
    input  logic [3:0] setSecond1,
    output logic [3:0] getHour10,
    output logic [3:0] getHour1,
    output logic [3:0] getMinute10,
    output logic [3:0] getMinute1,
    output logic [3:0] getSecond10,
    output logic [3:0] getSecond1,
    output logic       isZero,
    output logic       complete,
    output logic       alarm,
    output logic       running,
    output logic       paused
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam int unsigned CW = 24;

    localparam logic [PW-1:0] PRE_MAX    = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = 24'h00_00_01;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Count layout: {h10, h1, m10, m1, s10, s1}, one BCD nibble each.
    logic [1:0]    r_state;
    logic [PW-1:0] r_pre;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_shadow;
    logic          r_pend;
    logic          r_complete;
    logic          r_alarm;
    logic [AW-1:0] r_alarm_cnt;

    logic [1:0]    w_state_nx;
    logic [PW-1:0] w_pre_nx;
    logic [CW-1:0] w_cnt_nx;
    logic [CW-1:0] w_shadow_nx;
    logic          w_pend_nx;
    logic          w_complete_nx;
    logic          w_alarm_nx;
    logic [AW-1:0] w_alarm_cnt_nx;

    logic [CW-1:0] w_dec;
    logic [CW-1:0] w_load_val;
    logic          w_zero;
    logic          w_one;
    logic          w_tick;

    function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    assign w_load_val = {sat_digit(setHour10, 4'd9),   sat_digit(setHour1, 4'd9),
                         sat_digit(setMinute10, 4'd5), sat_digit(setMinute1, 4'd9),
                         sat_digit(setSecond10, 4'd5), sat_digit(setSecond1, 4'd9)};

    assign w_zero = (r_cnt == '0);
    assign w_one  = (r_cnt == CNT_ONE);
    assign w_tick = (r_state == S_RUN) && (r_pre == PRE_MAX);

    // Borrow-chain decrement; only used when the count is nonzero.
    always_comb begin
        w_dec = r_cnt;
        if (r_cnt[3:0] != 4'd0) begin
            w_dec[3:0] = r_cnt[3:0] - 4'd1;
        end else begin
            w_dec[3:0] = 4'd9;
            if (r_cnt[7:4] != 4'd0) begin
                w_dec[7:4] = r_cnt[7:4] - 4'd1;
            end else begin
                w_dec[7:4] = 4'd5;
                if (r_cnt[11:8] != 4'd0) begin
                    w_dec[11:8] = r_cnt[11:8] - 4'd1;
                end else begin
                    w_dec[11:8] = 4'd9;
                    if (r_cnt[15:12] != 4'd0) begin
                        w_dec[15:12] = r_cnt[15:12] - 4'd1;
                    end else begin
                        w_dec[15:12] = 4'd5;
                        if (r_cnt[19:16] != 4'd0) begin
                            w_dec[19:16] = r_cnt[19:16] - 4'd1;
                        end else begin
                            w_dec[19:16] = 4'd9;
                            w_dec[23:20] = r_cnt[23:20] - 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Next-state and datapath; control priority clear > load > pause > start.
    always_comb begin
        w_state_nx     = r_state;
        w_pre_nx       = r_pre;
        w_cnt_nx       = r_cnt;
        w_shadow_nx    = r_shadow;
        w_pend_nx      = 1'b0;
        w_complete_nx  = 1'b0;
        w_alarm_nx     = r_alarm;
        w_alarm_cnt_nx = r_alarm_cnt;

        // Expiry is flagged at the tick edge; complete and alarm follow one cycle later.
        if (clear) begin
            w_alarm_nx     = 1'b0;
            w_alarm_cnt_nx = '0;
        end else if (r_pend) begin
            w_complete_nx  = 1'b1;
            w_alarm_nx     = 1'b1;
            w_alarm_cnt_nx = ALARM_LOAD;
        end else if (r_alarm_cnt != '0) begin
            w_alarm_nx     = 1'b1;
            w_alarm_cnt_nx = r_alarm_cnt - AW'(1);
        end else begin
            w_alarm_nx     = 1'b0;
        end

        if (clear) begin
            w_state_nx = S_IDLE;
            w_pre_nx   = '0;
            w_cnt_nx   = '0;
        end else if (load && (r_state != S_RUN)) begin
            w_state_nx  = S_IDLE;
            w_pre_nx    = '0;
            w_cnt_nx    = w_load_val;
            w_shadow_nx = w_load_val;
        end else if (r_state == S_RUN) begin
            w_pre_nx = w_tick ? '0 : (r_pre + PW'(1));
            if (w_tick && w_one) begin
                w_pend_nx = 1'b1;
                if (AUTO_RELOAD != 0) begin
                    w_cnt_nx = r_shadow;
                end else begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_DONE;
                end
            end else if (w_tick && !w_zero) begin
                w_cnt_nx = w_dec;
            end
            if (pause && (w_state_nx == S_RUN)) begin
                w_state_nx = S_PAUSE;
            end
        end else if (start && !w_zero) begin
            if (r_state != S_PAUSE) begin
                w_pre_nx = '0;
            end
            w_state_nx = S_RUN;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_pre       <= '0;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_pend      <= 1'b0;
            r_complete  <= 1'b0;
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_pre       <= w_pre_nx;
            r_cnt       <= w_cnt_nx;
            r_shadow    <= w_shadow_nx;
            r_pend      <= w_pend_nx;
            r_complete  <= w_complete_nx;
            r_alarm     <= w_alarm_nx;
            r_alarm_cnt <= w_alarm_cnt_nx;
        end
    end

    assign getHour10   = r_cnt[23:20];
    assign getHour1    = r_cnt[19:16];
    assign getMinute10 = r_cnt[15:12];
    assign getMinute1  = r_cnt[11:8];
    assign getSecond10 = r_cnt[7:4];
    assign getSecond1  = r_cnt[3:0];
    assign isZero      = w_zero;
    assign complete    = r_complete;
    assign alarm       = r_alarm;
    assign running     = (r_state == S_RUN);
    assign paused      = (r_state == S_PAUSE);

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised HH:MM:SS BCD countdown timer; successor to the single-shot timer in the nap-timer path.
- Adds:
  - an internal 1 Hz prescaler;
  - load/start/pause/clear control;
  - full borrow-chain decrement;
  - BCD input sanitising;
  - optional auto-reload;
  - a stretched alarm output.
- Feeds the display digit outputs and the buzzer/alarm logic.

Parameters:
- TICK_DIV, 50000000: clock cycles per one-second tick; legal range ≥2.
- ALARM_CYCLES, 8: cycles alarm stays high after expiry; legal range ≥1.
- AUTO_RELOAD, 0: 1 = on expiry reload the loaded value and keep running; 0 = stop in DONE.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- load  in  1  capture set* digits; honoured only when not RUN
- start  in  1  begin/resume countdown
- pause  in  1  freeze countdown
- clear  in  1  synchronous clear to zero/IDLE
- setHour10, setHour1, setMinute10, setMinute1, setSecond10, setSecond1  in  4 each  BCD load value
- getHour10, getHour1, getMinute10, getMinute1, getSecond10, getSecond1  out  4 each  current BCD count
- isZero  out  1  count equals 00:00:00
- complete  out  1  one-cycle pulse on expiry
- alarm  out  1  high ALARM_CYCLES cycles from expiry
- running  out  1  state==RUN
- paused  out  1  state==PAUSE

Behaviour:
- Reset (reset=0, async): state IDLE, all get* digits 0, shadow reload regs 0, prescaler 0, isZero=1, complete=0, alarm=0, running=0, paused=0.
- All other updates on rising clock edge.
- Control priority per cycle: clear > load > pause > start.
- States: IDLE, RUN, PAUSE, DONE.

Transitions:
- clear: any state -> IDLE; digits 0; prescaler 0; alarm dropped to 0; shadow regs kept.
- load (state != RUN): digits and shadow regs <= sanitised set*; prescaler 0; state -> IDLE. Load in RUN is ignored.
- pause: RUN -> PAUSE; prescaler holds its value. Pause is ignored in other states.
- start with count nonzero: IDLE/PAUSE/DONE -> RUN.
  - From IDLE/DONE, prescaler is cleared to 0.
  - From PAUSE, prescaler resumes from its held value.
- start with count 00:00:00: ignored, no complete pulse.

Sanitising at load:
- Any digit >9 becomes 9.
- setSecond10 and setMinute10 >5 become 5.
- Hour digits are range 0-9 each (max 99 h).

Tick generation:
- In RUN, prescaler counts 0..TICK_DIV-1.
- tick is asserted in the cycle prescaler==TICK_DIV-1; prescaler wraps to 0 that cycle.
- First decrement is applied at the edge TICK_DIV cycles after the start edge.

Decrement on tick:
- Sec1-1; on borrow sec1=9 and sec10-1.
- Sec10 borrow -> 5, minute1-1.
- Minute1 borrow -> 9, minute10-1.
- Minute10 borrow -> 5, hour1-1.
- Hour1 borrow -> 9, hour10-1.
- Never decrements below 00:00:00.

Expiry (tick while count == 00:00:01, i.e. result zero):
- complete=1 for exactly the following cycle.
- alarm counter loaded; alarm high ALARM_CYCLES cycles starting the same cycle as complete.
- AUTO_RELOAD=0: state DONE, digits 0, isZero=1.
- AUTO_RELOAD=1: digits <= shadow regs on the same edge, state stays RUN, prescaler continues; the zero value is never visible on get*.
  - isZero stays 0 unless the shadow value is zero, which start rules prevent.

Flag rules:
- isZero is combinational from the current digits.
- running and paused are decoded from state.
- A new expiry while alarm is still high re-triggers the full ALARM_CYCLES.

Reset mid-count: immediate return to reset values; no complete pulse.

Test Plan:
- TICK_DIV=4. Load 00:00:03, start at cycle 0 -> seconds 2,1,0 at cycles 4,8,12; complete=1 at cycle 13 only; alarm high cycles 13-20 (ALARM_CYCLES=8); state DONE, isZero=1.
- Load 01:00:00, run one tick -> 00:59:59. Load 10:00:00, one tick -> 09:59:59 (full borrow chain).
- Load setSecond10=7, setMinute1=12, setHour1=15 -> reads H1=9, M1=9, S10=5.
- Load 00:00:05, start, pause after 1 tick plus 2 cycles, hold 20 cycles -> count stays 00:00:04. Resume -> next decrement 2 cycles after the resume edge.
- Load while RUN -> ignored. Same-cycle pause+start in RUN -> PAUSE. clear+load -> IDLE, digits 0. Start with 00:00:00 -> stays IDLE, no complete.
- AUTO_RELOAD=1, load 00:00:02, start -> sequence 2,1,2,1…; complete pulses every 8 cycles, isZero never 1. Drive reset low mid-run -> all outputs return to reset values immediately.
